// File: rtl/am_product_accumulator_if.sv
// Stream interface for the product accumulator: product beats in, one frame result out.
// The master side is the producer/consumer pair around the block; the slave side is the accumulator.
interface am_product_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 16
);
    localparam int CNT_W = $clog2(LEN + 1);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid,
        output in_prod,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_count,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_count,
        output out_ovf
    );
endinterface

// File: rtl/am_product_accumulator.sv
// Accumulates a frame of up to LEN unsigned products into a saturating ACC_W-bit sum
// and holds one result per frame until the downstream consumer takes it.
module am_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 16
) (
    input logic                      clk,
    input logic                      rst,
    am_product_accumulator_if.slave  acc_if
);
    localparam int CNT_W = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_ovf_q;

    logic               accept;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               ovf_d;
    logic               closing;

    assign accept = acc_if.in_valid && in_ready_q;

    // Candidate frame state if the current beat is taken; a beat in IDLE starts a fresh frame.
    always_comb begin
        sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(acc_if.in_prod);
        acc_d    = '0;
        cnt_d    = '0;
        ovf_d    = 1'b0;
        if (state_q == IDLE) begin
            acc_d = ACC_W'(acc_if.in_prod);
            cnt_d = CNT_W'(1);
            ovf_d = 1'b0;
        end else begin
            acc_d = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | sum_wide[ACC_W];
        end
        closing = acc_if.in_last || (cnt_d == CNT_W'(LEN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (closing) begin
                            out_sum_q   <= acc_d;
                            out_count_q <= cnt_d;
                            out_ovf_q   <= ovf_d;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            ovf_q       <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            acc_q       <= acc_d;
                            cnt_q       <= cnt_d;
                            ovf_q       <= ovf_d;
                            state_q     <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // The result stays put until taken; input reopens the cycle after the handshake.
                    if (acc_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign acc_if.in_ready  = in_ready_q;
    assign acc_if.out_valid = out_valid_q;
    assign acc_if.out_sum   = out_sum_q;
    assign acc_if.out_count = out_count_q;
    assign acc_if.out_ovf   = out_ovf_q;
endmodule
